// File: rtl/rv_pipe_pkg.sv
// Shared pipeline types for the writeback path.
// Register-file geometry and the queued writeback entry.
package rv_pipe_pkg;

   localparam int XLEN   = 32;
   localparam int REG_AW = 5;

   typedef struct packed {
      logic [REG_AW-1:0] rd;
      logic [XLEN-1:0]   data;
   } wb_entry_t;

   typedef enum logic [1:0] {
      SRC_NONE,
      SRC_PIPE,
      SRC_LLU
   } wb_src_e;

   typedef enum logic {
      ARB_RUN,
      ARB_STALL
   } arb_state_e;

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO of writeback entries.
// Exposes every slot plus a valid mask so callers can snoop queued rd's.
module wb_fifo
   import rv_pipe_pkg::*;
#(
   parameter int DEPTH = 2,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  push,
   input  wb_entry_t             push_data,
   input  logic                  pop,
   output wb_entry_t             head,
   output logic                  full,
   output logic                  empty,
   output logic [AW:0]           count,
   output wb_entry_t [DEPTH-1:0] ent,
   output logic [DEPTH-1:0]      vld
);

   wb_entry_t [DEPTH-1:0] mem;
   logic [AW-1:0]         wptr;
   logic [AW-1:0]         rptr;
   logic [AW:0]           cnt;
   logic                  do_push;
   logic                  do_pop;

   assign full    = (cnt == (AW+1)'(DEPTH));
   assign empty   = (cnt == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign count   = cnt;
   assign head    = mem[rptr];
   assign ent     = mem;

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wptr] <= push_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wptr <= '0;
         rptr <= '0;
         cnt  <= '0;
      end else begin
         if (do_push) begin
            wptr <= wptr + 1'b1;
         end
         if (do_pop) begin
            rptr <= rptr + 1'b1;
         end
         unique case ({do_push, do_pop})
            2'b10:   cnt <= cnt + 1'b1;
            2'b01:   cnt <= cnt - 1'b1;
            default: cnt <= cnt;
         endcase
      end
   end

   // slot i is live when its distance from the read pointer is below count
   always_comb begin
      logic [AW-1:0] off;
      off = '0;
      vld = '0;
      for (int i = 0; i < DEPTH; i++) begin
         off    = AW'(i) - rptr;
         vld[i] = ({1'b0, off} < cnt);
      end
   end

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the single register-file write port between the MEM/WB stage
// and queued long-latency-unit results, stalling when a result starves.
module wb_port_arbiter
   import rv_pipe_pkg::*;
#(
   parameter int FIFO_DEPTH = 2,
   parameter int STARVE_LIM = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wb_we_i,
   input  logic [REG_AW-1:0] wb_rd_i,
   input  logic [XLEN-1:0]   wb_data_i,
   input  logic              llu_valid_i,
   output logic              llu_ready_o,
   input  logic [REG_AW-1:0] llu_rd_i,
   input  logic [XLEN-1:0]   llu_data_i,
   output logic              rf_we_o,
   output logic [REG_AW-1:0] rf_rd_o,
   output logic [XLEN-1:0]   rf_wd_o,
   output logic              stall_o,
   input  logic [REG_AW-1:0] rs1_i,
   input  logic [REG_AW-1:0] rs2_i,
   output logic              rs1_pend_o,
   output logic              rs2_pend_o
);

   localparam int AW    = $clog2(FIFO_DEPTH);
   localparam int AGE_W = $clog2(STARVE_LIM + 1);

   arb_state_e                 state_q;
   arb_state_e                 state_d;
   logic [AGE_W-1:0]           age_q;
   logic [AGE_W-1:0]           age_d;
   wb_src_e                    src;
   logic                       pipe_v;
   logic                       accept;
   logic                       push;
   logic                       pop;
   logic                       full;
   logic                       empty;
   logic [AW:0]                fifo_cnt;
   wb_entry_t                  head;
   wb_entry_t                  push_data;
   wb_entry_t [FIFO_DEPTH-1:0] ent;
   logic [FIFO_DEPTH-1:0]      vld;

   assign pipe_v      = wb_we_i & (wb_rd_i != '0);
   assign llu_ready_o = ~rst & (fifo_cnt < (AW+1)'(FIFO_DEPTH));
   assign accept      = llu_valid_i & llu_ready_o;
   assign push        = accept & (llu_rd_i != '0) & ~full;
   assign push_data   = '{rd: llu_rd_i, data: llu_data_i};
   assign stall_o     = (state_q == ARB_STALL) & ~rst;
   assign pop         = (src == SRC_LLU);

   wb_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_data (push_data),
      .pop       (pop),
      .head      (head),
      .full      (full),
      .empty     (empty),
      .count     (fifo_cnt),
      .ent       (ent),
      .vld       (vld)
   );

   // a frozen pipeline re-presents its request, so the queue owns the stall cycle
   always_comb begin
      src = SRC_NONE;
      if (rst) begin
         src = SRC_NONE;
      end else if (state_q == ARB_STALL) begin
         src = empty ? SRC_NONE : SRC_LLU;
      end else if (pipe_v) begin
         src = SRC_PIPE;
      end else if (!empty) begin
         src = SRC_LLU;
      end
   end

   always_comb begin
      rf_we_o = 1'b0;
      rf_rd_o = '0;
      rf_wd_o = '0;
      unique case (src)
         SRC_PIPE: begin
            rf_we_o = 1'b1;
            rf_rd_o = wb_rd_i;
            rf_wd_o = wb_data_i;
         end
         SRC_LLU: begin
            rf_we_o = 1'b1;
            rf_rd_o = head.rd;
            rf_wd_o = head.data;
         end
         default: begin
            rf_we_o = 1'b0;
         end
      endcase
   end

   // age tracks how long the current head has waited
   always_comb begin
      age_d   = age_q;
      state_d = state_q;
      if (pop || empty) begin
         age_d = '0;
      end else if (age_q != AGE_W'(STARVE_LIM)) begin
         age_d = age_q + 1'b1;
      end
      state_d = (age_d == AGE_W'(STARVE_LIM)) ? ARB_STALL : ARB_RUN;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ARB_RUN;
         age_q   <= '0;
      end else begin
         state_q <= state_d;
         age_q   <= age_d;
      end
   end

   always_comb begin
      rs1_pend_o = 1'b0;
      rs2_pend_o = 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
         if (vld[i] && ent[i].rd == rs1_i) begin
            rs1_pend_o = 1'b1;
         end
         if (vld[i] && ent[i].rd == rs2_i) begin
            rs2_pend_o = 1'b1;
         end
      end
      if (rst || rs1_i == '0) begin
         rs1_pend_o = 1'b0;
      end
      if (rst || rs2_i == '0) begin
         rs2_pend_o = 1'b0;
      end
   end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Bench for wb_port_arbiter: directed scenarios plus random traffic
// against a queue-based model of the writeback port.
module tb_wb_port_arbiter;

   localparam int D   = 2;
   localparam int LIM = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        wb_we_i;
   logic [4:0]  wb_rd_i;
   logic [31:0] wb_data_i;
   logic        llu_valid_i;
   logic        llu_ready_o;
   logic [4:0]  llu_rd_i;
   logic [31:0] llu_data_i;
   logic        rf_we_o;
   logic [4:0]  rf_rd_o;
   logic [31:0] rf_wd_o;
   logic        stall_o;
   logic [4:0]  rs1_i;
   logic [4:0]  rs2_i;
   logic        rs1_pend_o;
   logic        rs2_pend_o;

   always #5 clk = ~clk;

   wb_port_arbiter #(
      .FIFO_DEPTH (D),
      .STARVE_LIM (LIM)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .wb_we_i     (wb_we_i),
      .wb_rd_i     (wb_rd_i),
      .wb_data_i   (wb_data_i),
      .llu_valid_i (llu_valid_i),
      .llu_ready_o (llu_ready_o),
      .llu_rd_i    (llu_rd_i),
      .llu_data_i  (llu_data_i),
      .rf_we_o     (rf_we_o),
      .rf_rd_o     (rf_rd_o),
      .rf_wd_o     (rf_wd_o),
      .stall_o     (stall_o),
      .rs1_i       (rs1_i),
      .rs2_i       (rs2_i),
      .rs1_pend_o  (rs1_pend_o),
      .rs2_pend_o  (rs2_pend_o)
   );

   typedef struct {
      logic [4:0]  rd;
      logic [31:0] d;
   } ent_t;

   ent_t q[$];
   int   head_since = 0;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;

   logic        e_we, e_stall, e_ready, e_p1, e_p2, e_pop, e_acc;
   logic [4:0]  e_rd;
   logic [31:0] e_wd;

   task automatic chk1(string nm, logic act, logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cyc=%0d got=%b want=%b", nm, cyc, act, exp);
      end
   endtask

   task automatic chk32(string nm, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
      end
   endtask

   // expected outputs from the queue contents and this cycle's inputs
   task automatic model_eval();
      e_ready = !rst && (q.size() < D);
      e_stall = !rst && (q.size() > 0) && (cyc - head_since == LIM);
      e_pop = 1'b0;
      e_we  = 1'b0;
      e_rd  = '0;
      e_wd  = '0;
      if (!rst) begin
         if (e_stall || (!(wb_we_i && wb_rd_i != 0) && q.size() > 0)) begin
            e_pop = 1'b1;
            e_we  = 1'b1;
            e_rd  = q[0].rd;
            e_wd  = q[0].d;
         end else if (wb_we_i && wb_rd_i != 0) begin
            e_we = 1'b1;
            e_rd = wb_rd_i;
            e_wd = wb_data_i;
         end
      end
      e_p1 = 1'b0;
      e_p2 = 1'b0;
      foreach (q[k]) begin
         if (q[k].rd == rs1_i) e_p1 = 1'b1;
         if (q[k].rd == rs2_i) e_p2 = 1'b1;
      end
      if (rst || rs1_i == 0) e_p1 = 1'b0;
      if (rst || rs2_i == 0) e_p2 = 1'b0;
      e_acc = llu_valid_i && e_ready;
   endtask

   task automatic compare();
      model_eval();
      chk1("ready", llu_ready_o, e_ready);
      chk1("stall", stall_o, e_stall);
      chk1("rf_we", rf_we_o, e_we);
      chk32("rf_rd", {27'b0, rf_rd_o}, {27'b0, e_rd});
      chk32("rf_wd", rf_wd_o, e_wd);
      chk1("pend1", rs1_pend_o, e_p1);
      chk1("pend2", rs2_pend_o, e_p2);
   endtask

   task automatic drive(input logic we, input logic [4:0] rd,
                        input logic [31:0] data, input logic lv,
                        input logic [4:0] lrd, input logic [31:0] ldata,
                        input logic [4:0] r1, input logic [4:0] r2,
                        input logic r);
      @(negedge clk);
      wb_we_i     = we;
      wb_rd_i     = rd;
      wb_data_i   = data;
      llu_valid_i = lv;
      llu_rd_i    = lrd;
      llu_data_i  = ldata;
      rs1_i       = r1;
      rs2_i       = r2;
      rst         = r;
      #1;
      compare();
   endtask

   task automatic idle(input logic [4:0] r1);
      drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, r1, 5'd0, 1'b0);
   endtask

   task automatic tick();
      bit was_empty;
      @(posedge clk);
      if (rst) begin
         q.delete();
      end else begin
         was_empty = (q.size() == 0);
         if (e_pop) void'(q.pop_front());
         if (e_acc && llu_rd_i != 0) q.push_back('{rd: llu_rd_i, d: llu_data_i});
         if (q.size() > 0 && (e_pop || was_empty)) head_since = cyc + 1;
      end
      cyc++;
   endtask

   initial begin
      int acc_at;
      int busy;
      logic lv;
      rst = 1'b1;
      wb_we_i = 0; wb_rd_i = 0; wb_data_i = 0;
      llu_valid_i = 0; llu_rd_i = 0; llu_data_i = 0;
      rs1_i = 0; rs2_i = 0;

      repeat (2) begin
         drive(1'b1, 5'd7, 32'h7, 1'b1, 5'd3, 32'h3, 5'd3, 5'd0, 1'b1);
         chk1("rst_ready", llu_ready_o, 1'b0);
         chk1("rst_we", rf_we_o, 1'b0);
         chk1("rst_stall", stall_o, 1'b0);
         tick();
      end

      // single LLU result into an idle pipeline
      drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'hDEADBEEF, 5'd0, 5'd0, 1'b0);
      chk1("t31_ready", llu_ready_o, 1'b1);
      chk1("t31_nobypass", rf_we_o, 1'b0);
      tick();
      idle(5'd0);
      chk1("t31_we", rf_we_o, 1'b1);
      chk32("t31_rd", {27'b0, rf_rd_o}, 32'd5);
      chk32("t31_wd", rf_wd_o, 32'hDEADBEEF);
      chk1("t31_stall", stall_o, 1'b0);
      tick();
      idle(5'd0);
      chk1("t31_drained", rf_we_o, 1'b0);
      tick();

      // rd=0 result is dropped
      drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h1234, 5'd0, 5'd0, 1'b0);
      tick();
      idle(5'd0);
      chk1("t34_we", rf_we_o, 1'b0);
      tick();

      // pending lookup
      drive(1'b1, 5'd7, 32'h77, 1'b1, 5'd3, 32'h33, 5'd0, 5'd0, 1'b0);
      tick();
      drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd3, 5'd0, 1'b0);
      chk1("t35_p1", rs1_pend_o, 1'b1);
      chk1("t35_p2", rs2_pend_o, 1'b0);
      chk32("t35_pop", {27'b0, rf_rd_o}, 32'd3);
      tick();
      drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd3, 5'd0, 1'b0);
      chk1("t35_p1_after", rs1_pend_o, 1'b0);
      tick();

      // starvation forces a one-cycle stall
      for (int i = 0; i < 8; i++) begin
         drive(1'b1, 5'd7, 32'h700 + i, i == 0, 5'd9, 32'h99, 5'd0, 5'd0, 1'b0);
         if (i >= 1 && i <= 4) begin
            chk32("t32_pipe", {27'b0, rf_rd_o}, 32'd7);
            chk1("t32_nostall", stall_o, 1'b0);
         end
         if (i == 5) begin
            chk1("t32_stall", stall_o, 1'b1);
            chk32("t32_llu_rd", {27'b0, rf_rd_o}, 32'd9);
            chk32("t32_llu_wd", rf_wd_o, 32'h99);
         end
         if (i == 6) begin
            chk1("t32_unstall", stall_o, 1'b0);
            chk32("t32_resume", {27'b0, rf_rd_o}, 32'd7);
         end
         tick();
      end

      // backpressure when full, third result held until a pop
      acc_at = -1;
      for (int i = 0; i < 12; i++) begin
         lv = (i < 2) || (acc_at < 0);
         drive(1'b1, 5'd7, 32'h70, lv, (i < 2) ? 5'(10 + i) : 5'd12,
               32'hA0 + i, 5'd0, 5'd0, 1'b0);
         if (i == 2) chk1("t33_full", llu_ready_o, 1'b0);
         if (i == 5) chk1("t33_nopassthru", llu_ready_o, 1'b0);
         if (i == 6) chk1("t33_ready", llu_ready_o, 1'b1);
         if (i >= 2 && lv && llu_ready_o && acc_at < 0) acc_at = i;
         tick();
      end
      chk32("t33_accept_cycle", acc_at, 32'd6);
      repeat (3) begin
         idle(5'd0);
         tick();
      end

      // reset discards queued work
      drive(1'b1, 5'd7, 32'h1, 1'b1, 5'd20, 32'h20, 5'd0, 5'd0, 1'b0);
      tick();
      drive(1'b1, 5'd7, 32'h2, 1'b1, 5'd21, 32'h21, 5'd0, 5'd0, 1'b0);
      tick();
      drive(1'b1, 5'd7, 32'h3, 1'b0, 5'd0, 32'd0, 5'd20, 5'd0, 1'b1);
      chk1("t36_we", rf_we_o, 1'b0);
      chk1("t36_stall", stall_o, 1'b0);
      chk1("t36_ready_rst", llu_ready_o, 1'b0);
      tick();
      idle(5'd20);
      chk1("t36_ready", llu_ready_o, 1'b1);
      chk1("t36_no_write", rf_we_o, 1'b0);
      chk1("t36_pend", rs1_pend_o, 1'b0);
      tick();

      // random traffic
      busy = 50;
      for (int n = 0; n < 4000; n++) begin
         if (n % 64 == 0) busy = $urandom_range(0, 100);
         drive(($urandom_range(0, 99) < busy),
               ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
               $urandom(),
               $urandom_range(0, 1) == 1,
               5'($urandom_range(0, 7)),
               $urandom(),
               5'($urandom_range(0, 7)),
               5'($urandom_range(0, 7)),
               $urandom_range(0, 299) == 0);
         tick();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
